// File: rtl/noc_pkg.sv
// Shared router definitions: default flit width and the port-direction enum used by
// the input buffers, output arbiters and routing logic.
package noc_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned NumDirs          = 5;

  typedef enum logic [2:0] {
    DirN = 3'd0,
    DirE = 3'd1,
    DirW = 3'd2,
    DirS = 3'd3,
    DirL = 3'd4
  } port_dir_e;

endpackage

// File: rtl/fifo_handshake_receiver_if.sv
// RTS/CTS flit link into one router input port plus the local pop/head-flit side.
// master: upstream arbiter and local output arbiters; slave: the input buffer.
interface fifo_handshake_receiver_if
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
);

  logic [DATA_WIDTH-1:0] RX;
  logic                  DRTS;
  logic                  CTS;
  logic                  read_en_N;
  logic                  read_en_E;
  logic                  read_en_W;
  logic                  read_en_S;
  logic                  read_en_L;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  empty;
  logic                  full;

  modport master (
    output RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    input  CTS, Data_out, empty, full
  );

  modport slave (
    input  RX, DRTS, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
    output CTS, Data_out, empty, full
  );

endinterface

// File: rtl/fifo_handshake_receiver_storage.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous
// read port, all words cleared on reset.
module fifo_storage
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage words: cleared on reset, written at waddr when we is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_handshake_receiver.sv
// Router input-port buffer: receiving end of the RTS/CTS flit handshake, a small
// circular FIFO, and the head flit presented to the local arbiters.
module fifo_handshake_receiver
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DEPTH      = 4
) (
  input logic                       clk,
  input logic                       rst,
  fifo_handshake_receiver_if.slave  bus
);

  localparam int unsigned PtrWidth = $clog2(DEPTH);
  localparam int unsigned CntWidth = PtrWidth + 1;

  logic                cts_q, cts_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;

  logic [NumDirs-1:0]    read_en;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] head;

  // Gather the per-direction grants; several high at once still pops one flit.
  always_comb begin
    read_en       = '0;
    read_en[DirN] = bus.read_en_N;
    read_en[DirE] = bus.read_en_E;
    read_en[DirW] = bus.read_en_W;
    read_en[DirS] = bus.read_en_S;
    read_en[DirL] = bus.read_en_L;
  end

  assign wr_en = cts_q & bus.DRTS;
  assign rd_en = (|read_en) & ~empty_q;

  // Next-state for handshake, pointers and occupancy.
  always_comb begin
    // CTS is only raised from a cycle with no write in flight, so full_q is exact here
    // and the granted slot cannot be taken before the flit lands.
    cts_d    = bus.DRTS & ~cts_q & ~full_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PtrWidth'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PtrWidth'(1) : rd_ptr_q;
    count_d  = count_q + CntWidth'(wr_en) - CntWidth'(rd_en);
    empty_d  = (count_d == '0);
    full_d   = (count_d == CntWidth'(DEPTH));
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cts_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      cts_q    <= cts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (bus.RX),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign bus.CTS      = cts_q;
  assign bus.Data_out = head;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;

endmodule

// File: doc/fifo_handshake_receiver.md
# fifo_handshake_receiver

Input-port buffer for one router port: the receiving end of the RTS/CTS flit handshake driven by a neighbour's output arbiter. It accepts one flit per handshake from upstream, stores it in a small circular FIFO, and presents the head flit to the local routing and arbitration logic. The local output arbiters pop the head flit through per-direction read enables. One instance sits on each of the N/E/W/S/L inputs of the router.

## Interface
Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, number of FIFO slots; must be a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- RX  in  DATA_WIDTH  flit from upstream; valid whenever DRTS is high.
- DRTS  in  1  upstream request-to-send (upstream arbiter's RTS).
- CTS  out  1  clear-to-send to upstream (upstream arbiter's DCTS); registered.
- read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  in  1 each  pop requests from the local output arbiters (their grants).
- Data_out  out  DATA_WIDTH  head flit, mem[rd_ptr], combinational from storage.
- empty  out  1  FIFO holds zero flits.
- full  out  1  FIFO holds DEPTH flits.

## Operation
- Reset (rst low, asynchronous): CTS=0, rd_ptr=wr_ptr=0, count=0, empty=1, full=0, all storage words cleared to 0, so Data_out=0.
- CTS generation, registered: CTS_next = DRTS & ~CTS & ~full. CTS is therefore never high in two consecutive cycles.
- Write: occurs in every cycle where CTS=1 and DRTS=1. RX is stored at mem[wr_ptr], and wr_ptr advances modulo DEPTH.
  - CTS=1 with DRTS=0 (upstream withdrew) writes nothing.
- Read: read_en = OR of the five read_en_* inputs. If read_en=1 and empty=0, rd_ptr advances modulo DEPTH. A read while empty is ignored, with no pointer or count change.
- Count: count_next = count + write − valid_read, with width log2(DEPTH)+1.
  - empty = (count==0); full = (count==DEPTH). Both are registered, derived from count.
- Simultaneous write and read: both pointers advance and count is unchanged.
  - This is legal at count==0: the read is ignored because empty=1, so count becomes 1.
  - This is legal at count==DEPTH: it cannot arise, because CTS is never granted while full.
- Overflow is impossible by construction. CTS is decided on ~full in a cycle with no write, and count cannot rise between the decision and the write.
- More than one read_en_* high at once is an upstream arbiter fault. The block still pops only one flit.
- Reset asserted mid-handshake drops CTS immediately and discards all stored flits. The upstream side is reset in the same domain.

## Timing
- Handshake: DRTS rises in cycle t → CTS=1 in cycle t+1 → flit captured on the edge ending t+1 → empty=0 and Data_out=flit in t+2.
- The upstream arbiter sees RTS & DCTS in t+1 and drops RTS in t+2. Peak throughput is one flit per 2 cycles.
- Full: if full=1 in cycle t while DRTS=1, CTS stays 0. After a read in t, full=0 in t+1, and CTS=1 in t+2.
- Read latency: Data_out shows the next flit in the cycle after a pop.
- Pointer wrap: after DEPTH writes, wr_ptr returns to 0, with no bubble.

## Structure
- Shared package noc_pkg holds the default DATA_WIDTH constant and the port-direction enum (N, E, W, S, L), which is shared with the arbiter and routing logic.
- Storage is a natural sub-module: fifo_storage, a DEPTH×DATA_WIDTH register array with a write port and an asynchronous read port, plus reset-to-zero.
- CTS, pointer and count logic stay in the top module.

## Test plan
- Reset then idle: rst low for 2 cycles, DRTS=0 → CTS=0, empty=1, full=0, Data_out=0 throughout.
- Single flit: DRTS=1 with RX=0xA5A5_0001 held until CTS seen → CTS high for exactly 1 cycle, empty=0 two cycles after DRTS rises, Data_out=0xA5A5_0001.
  - Then read_en_E for 1 cycle → empty=1.
- Fill to full: 4 back-to-back handshakes with RX=1,2,3,4 and no reads → full=1. A further DRTS=1 keeps CTS=0 for 10 cycles.
  - Then read_en_N once → Data_out=2, and CTS pulses 2 cycles later, capturing RX=5.
- Simultaneous read and write at count=2: count stays 2, and FIFO order is preserved (pops return 3,4 then 5 in sequence after the first test).
- Wrap-around: push and pop 10 flits (values 0x10–0x19) → popped in order, with pointers wrapping twice and no loss.
- Async reset mid-operation: rst low while CTS=1 and count=3 → CTS=0, empty=1 immediately, without waiting for a clk edge, and Data_out=0.
